cache_fill_arbiter: RTL and testbench

- Shared miss-handling engine for the split I/D cache pair.
- Arbitrates round-robin between instruction-cache and data-cache miss requests and fetches the full block from pipelined multi-cycle main memory in critical-word-first (wrapped) order.
- Drives data-array and tag-array writes, and gives the granted requester an early-restart pulse plus a completion pulse.
- Successor to the single-requester fill FSM: block size, widths and memory latency are parameters; arbitration and wrapped fill are new.

---
 rtl/cache_pkg.sv | 39 +++
 rtl/rr_arbiter2.sv | 39 +++
 rtl/cache_fill_arbiter.sv | 163 ++++++++++++++++
 tb/tb_cache_fill_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache fill engine.
//   fill_state_e     : fill engine states
//   REQ_I / REQ_D    : requester IDs (bit positions of miss_req / fill_done)
//   OFFSET_W         : byte-offset width of a block at the default geometry
//   block_word_addr  : byte address of word idx within the block holding base
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } fill_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // OFFSET_W describes the default 8-word block; the fill engine derives
  // its own offset width from its WORDS parameter.
  localparam int WORDS_DEFAULT = 8;
  localparam int OFFSET_W      = $clog2(WORDS_DEFAULT) + 1;

  // Wide enough for any supported ADDR_W; callers cast to their width.
  localparam int ADDR_MAX_W = 32;

  // Keeps the tag/index bits of base, replaces the word index with idx
  // (modulo 2**idx_w) and forces the byte-in-word bit to 0.
  function automatic logic [ADDR_MAX_W-1:0] block_word_addr(
    input logic [ADDR_MAX_W-1:0] base,
    input logic [ADDR_MAX_W-1:0] idx,
    input int                    idx_w
  );
    logic [ADDR_MAX_W-1:0] word_mask;
    logic [ADDR_MAX_W-1:0] offset_mask;
    word_mask   = (ADDR_MAX_W'(1) << idx_w) - ADDR_MAX_W'(1);
    offset_mask = (word_mask << 1) | ADDR_MAX_W'(1);
    return (base & ~offset_mask) | ((idx & word_mask) << 1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter for the I/D miss requests.
//   clk, rst   : clock, synchronous active-low reset
//   req        : request bits (bit0 = I, bit1 = D)
//   grant_en   : commit strobe; last_grant only moves when a grant is taken
//   grant_id   : winning requester (valid when grant_any)
//   grant_any  : at least one request pending
module rr_arbiter2
  import cache_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       grant_id,
  output logic       grant_any
);

  logic last_grant;

  // On a tie the side that did not win last time goes first.
  always_comb begin
    grant_any = |req;
    grant_id  = REQ_I;
    if (req[REQ_I] && req[REQ_D]) begin
      grant_id = ~last_grant;
    end else if (req[REQ_D]) begin
      grant_id = REQ_D;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= REQ_I;
    end else if (grant_en) begin
      last_grant <= grant_id;
    end
  end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shared miss-handling engine for the split I/D caches. Picks one miss
// round-robin, streams the block from pipelined memory in critical-word-
// first order, writes the data array word by word, then writes the tag.
//   clk, rst           : clock, synchronous active-low reset
//   miss_req           : bit0 = I miss, bit1 = D miss (held until fill_done)
//   miss_addr_i/_d     : miss byte addresses
//   busy, grant_id     : fill in progress / serviced side (0 = I, 1 = D)
//   mem_en, mem_addr   : memory read issue
//   mem_data_valid/_data : in-order read returns
//   write_data_array, fill_word_idx, fill_data : data-array write
//   write_tag_array, fill_addr : tag/valid write and latched miss address
//   critical_valid     : missed word written (early restart)
//   fill_done          : completion pulse to the serviced requester
//
// state | meaning
// IDLE  | waiting for a miss; grants and latches the address
// FILL  | issuing reads and writing returned words
// TAG   | one cycle: tag write and fill_done, then back to IDLE
module cache_fill_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS           = 8,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               miss_req,
  input  logic [ADDR_W-1:0]        miss_addr_i,
  input  logic [ADDR_W-1:0]        miss_addr_d,
  output logic                     busy,
  output logic                     grant_id,
  output logic                     mem_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_data_valid,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     write_data_array,
  output logic [$clog2(WORDS)-1:0] fill_word_idx,
  output logic [DATA_W-1:0]        fill_data,
  output logic                     write_tag_array,
  output logic [ADDR_W-1:0]        fill_addr,
  output logic                     critical_valid,
  output logic [1:0]               fill_done
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WORDS - 1);

  fill_state_e       state, state_nxt;
  logic [IDX_W-1:0]  start_idx;
  logic [CNT_W-1:0]  issue_cnt, ret_cnt, outstanding;
  logic [IDX_W-1:0]  issue_idx, ret_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic              arb_id, arb_any, grant_en;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (miss_req),
    .grant_en  (grant_en),
    .grant_id  (arb_id),
    .grant_any (arb_any)
  );

  assign sel_addr    = (arb_id == REQ_D) ? miss_addr_d : miss_addr_i;
  assign outstanding = issue_cnt - ret_cnt;
  // Word slots wrap naturally in IDX_W bits.
  assign issue_idx   = start_idx + issue_cnt[IDX_W-1:0];
  assign ret_idx     = start_idx + ret_cnt[IDX_W-1:0];
  assign fill_data   = mem_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    busy             = 1'b0;
    grant_en         = 1'b0;
    mem_en           = 1'b0;
    mem_addr         = '0;
    write_data_array = 1'b0;
    fill_word_idx    = '0;
    critical_valid   = 1'b0;
    write_tag_array  = 1'b0;
    fill_done        = '0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          grant_en  = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        busy = 1'b1;
        if (issue_cnt < WORDS_C && int'(outstanding) < MAX_OUTSTANDING) begin
          mem_en   = 1'b1;
          mem_addr = ADDR_W'(block_word_addr(ADDR_MAX_W'(fill_addr),
                                             ADDR_MAX_W'(issue_idx), IDX_W));
        end
        // Returns beyond the block are dropped; ret_cnt saturates at WORDS.
        if (mem_data_valid && ret_cnt < WORDS_C) begin
          write_data_array = 1'b1;
          fill_word_idx    = ret_idx;
          critical_valid   = (ret_cnt == '0);
          if (ret_cnt == LAST_C) begin
            state_nxt = TAG;
          end
        end
      end
      TAG: begin
        busy            = 1'b1;
        write_tag_array = 1'b1;
        // A requester that gave up mid-fill gets no completion pulse.
        fill_done[grant_id] = miss_req[grant_id];
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fill_addr <= '0;
      grant_id  <= REQ_I;
      start_idx <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_en) begin
            fill_addr <= sel_addr;
            grant_id  <= arb_id;
            start_idx <= sel_addr[IDX_W:1];
            issue_cnt <= '0;
            ret_cnt   <= '0;
          end
        end
        FILL: begin
          if (mem_en) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
          end
          if (write_data_array) begin
            ret_cnt <= ret_cnt + CNT_W'(1);
          end
        end
        default: begin
          issue_cnt <= '0;
          ret_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter: a latency-4 memory behind the main
// instance and a latency-10 memory behind a second instance limited to two
// outstanding reads.
module tb_cache_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  miss_req, miss_req2;
  logic [15:0] miss_addr_i, miss_addr_d, miss_addr_i2, miss_addr_d2;
  logic        busy, grant_id, mem_en, write_data_array, write_tag_array, critical_valid;
  logic [15:0] mem_addr, fill_data, fill_addr, mem_data;
  logic [2:0]  fill_word_idx;
  logic [1:0]  fill_done;
  logic        mem_data_valid;
  logic        busy2, grant_id2, mem_en2, wr2, tag2, crit2;
  logic [15:0] mem_addr2, fill_data2, fill_addr2, mem_data2;
  logic [2:0]  idx2;
  logic [1:0]  done2;
  logic        mem_data_valid2;

  logic        stray_valid = 1'b0;
  logic [15:0] stray_data  = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_fill_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS(8), .MAX_OUTSTANDING(8)) u_dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr_i(miss_addr_i),
    .miss_addr_d(miss_addr_d), .busy(busy), .grant_id(grant_id), .mem_en(mem_en),
    .mem_addr(mem_addr), .mem_data_valid(mem_data_valid), .mem_data(mem_data),
    .write_data_array(write_data_array), .fill_word_idx(fill_word_idx),
    .fill_data(fill_data), .write_tag_array(write_tag_array), .fill_addr(fill_addr),
    .critical_valid(critical_valid), .fill_done(fill_done)
  );

  cache_fill_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS(8), .MAX_OUTSTANDING(2)) u_dut2 (
    .clk(clk), .rst(rst), .miss_req(miss_req2), .miss_addr_i(miss_addr_i2),
    .miss_addr_d(miss_addr_d2), .busy(busy2), .grant_id(grant_id2), .mem_en(mem_en2),
    .mem_addr(mem_addr2), .mem_data_valid(mem_data_valid2), .mem_data(mem_data2),
    .write_data_array(wr2), .fill_word_idx(idx2), .fill_data(fill_data2),
    .write_tag_array(tag2), .fill_addr(fill_addr2), .critical_valid(crit2),
    .fill_done(done2)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // Memory models: issues sampled mid-cycle, answered LAT cycles later.
  int unsigned cyc = 0;
  logic        samp_en [2];
  logic [15:0] samp_addr [2];
  logic        samp_rst = 1'b0;
  logic [15:0] pend_addr [2][16];
  int unsigned pend_due [2][16];
  int          wp [2] = '{0, 0};
  int          rp [2] = '{0, 0};
  logic        mv [2] = '{1'b0, 1'b0};
  logic [15:0] md [2] = '{16'h0, 16'h0};

  always @(negedge clk) begin
    samp_en[0]   = mem_en;
    samp_addr[0] = mem_addr;
    samp_en[1]   = mem_en2;
    samp_addr[1] = mem_addr2;
    samp_rst     = rst;
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!samp_rst) begin
        wp[i] = 0;
        rp[i] = 0;
      end else if (samp_en[i] === 1'b1) begin
        pend_addr[i][wp[i]] = samp_addr[i];
        pend_due[i][wp[i]]  = cyc + ((i == 0) ? 32'd4 : 32'd10);
        wp[i] = (wp[i] + 1) % 16;
      end
    end
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rp[i] != wp[i] && pend_due[i][rp[i]] == cyc) begin
        mv[i] = 1'b1;
        md[i] = mem_word(pend_addr[i][rp[i]]);
        rp[i] = (rp[i] + 1) % 16;
      end else begin
        mv[i] = 1'b0;
        md[i] = '0;
      end
    end
  end

  assign mem_data_valid  = mv[0] | stray_valid;
  assign mem_data        = mv[0] ? md[0] : stray_data;
  assign mem_data_valid2 = mv[1];
  assign mem_data2       = md[1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits for fill_done, returning what was seen in the TAG cycle; leaves
  // the caller at the start of the following (IDLE) cycle.
  task automatic wait_done(output logic [1:0] done, output logic gid, output logic [15:0] faddr);
    done  = '0;
    gid   = 1'b0;
    faddr = '0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (fill_done != 2'b00) begin
        done  = fill_done;
        gid   = grant_id;
        faddr = fill_addr;
        break;
      end
    end
    next_cycle();
  endtask

  typedef struct {
    logic [1:0]  req;
    logic        busy;
    logic        en;
    logic [15:0] addr;
    logic        wr;
    logic [2:0]  idx;
    logic        crit;
    logic        tag;
    logic [1:0]  done;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] req, input logic b, input logic en,
                              input logic [15:0] addr, input logic wr, input logic [2:0] idx,
                              input logic crit, input logic tag, input logic [1:0] done);
    vec_t v;
    v.req = req; v.busy = b; v.en = en; v.addr = addr; v.wr = wr;
    v.idx = idx; v.crit = crit; v.tag = tag; v.done = done;
    return v;
  endfunction

  vec_t tbl [15];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0]  done;
    logic        gid;
    logic [15:0] faddr;
    int          n_iss, n_ret, stalls, nwr;
    logic        got, saw_tag, saw_done, exp_en;

    // Single I miss at 0x1236, latency 4; row k is cycle T+k.
    tbl[0]  = mk(2'b01, 0, 0, 16'h0000, 0, 0, 0, 0, 2'b00);
    tbl[1]  = mk(2'b01, 1, 1, 16'h1236, 0, 0, 0, 0, 2'b00);
    tbl[2]  = mk(2'b01, 1, 1, 16'h1238, 0, 0, 0, 0, 2'b00);
    tbl[3]  = mk(2'b01, 1, 1, 16'h123A, 0, 0, 0, 0, 2'b00);
    tbl[4]  = mk(2'b01, 1, 1, 16'h123C, 0, 0, 0, 0, 2'b00);
    tbl[5]  = mk(2'b01, 1, 1, 16'h123E, 1, 3, 1, 0, 2'b00);
    tbl[6]  = mk(2'b01, 1, 1, 16'h1230, 1, 4, 0, 0, 2'b00);
    tbl[7]  = mk(2'b01, 1, 1, 16'h1232, 1, 5, 0, 0, 2'b00);
    tbl[8]  = mk(2'b01, 1, 1, 16'h1234, 1, 6, 0, 0, 2'b00);
    tbl[9]  = mk(2'b01, 1, 0, 16'h0000, 1, 7, 0, 0, 2'b00);
    tbl[10] = mk(2'b01, 1, 0, 16'h0000, 1, 0, 0, 0, 2'b00);
    tbl[11] = mk(2'b01, 1, 0, 16'h0000, 1, 1, 0, 0, 2'b00);
    tbl[12] = mk(2'b01, 1, 0, 16'h0000, 1, 2, 0, 0, 2'b00);
    tbl[13] = mk(2'b01, 1, 0, 16'h0000, 0, 0, 0, 1, 2'b01);
    tbl[14] = mk(2'b00, 0, 0, 16'h0000, 0, 0, 0, 0, 2'b00);

    rst = 1'b0;
    miss_req = '0; miss_addr_i = '0; miss_addr_d = '0;
    miss_req2 = '0; miss_addr_i2 = '0; miss_addr_d2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_write_data", write_data_array, 0);
    chk("rst_word_idx", fill_word_idx, 0);
    chk("rst_write_tag", write_tag_array, 0);
    chk("rst_fill_addr", fill_addr, 0);
    chk("rst_critical", critical_valid, 0);
    chk("rst_fill_done", fill_done, 0);
    next_cycle();
    rst = 1'b1;

    // Both misses at once: D first (last_grant resets to I), then I.
    miss_addr_d = 16'h4000; miss_addr_i = 16'h0010; miss_req = 2'b11;
    wait_done(done, gid, faddr);
    chk("both_first_gid", gid, 1);
    chk("both_first_done", done, 2'b10);
    chk("both_first_addr", faddr, 16'h4000);
    miss_req = 2'b01;
    wait_done(done, gid, faddr);
    chk("both_second_gid", gid, 0);
    chk("both_second_done", done, 2'b01);
    chk("both_second_addr", faddr, 16'h0010);
    miss_req = 2'b00;

    // Both held high across three fills: D, I, D.
    miss_req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_done(done, gid, faddr);
      chk($sformatf("alt%0d_gid", k), gid, (k == 1) ? 32'd0 : 32'd1);
      chk($sformatf("alt%0d_done", k), done, (k == 1) ? 32'd1 : 32'd2);
    end
    miss_req = 2'b00;
    next_cycle();

    // Table-driven single I miss.
    miss_addr_i = 16'h1236;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) next_cycle();
      miss_req = tbl[k].req;
      @(negedge clk);
      chk($sformatf("t%0d_busy", k), busy, tbl[k].busy);
      chk($sformatf("t%0d_mem_en", k), mem_en, tbl[k].en);
      if (tbl[k].en) chk($sformatf("t%0d_mem_addr", k), mem_addr, tbl[k].addr);
      chk($sformatf("t%0d_write_data", k), write_data_array, tbl[k].wr);
      if (tbl[k].wr) begin
        chk($sformatf("t%0d_word_idx", k), fill_word_idx, tbl[k].idx);
        chk($sformatf("t%0d_fill_data", k), fill_data,
            mem_word(16'h1230 | {12'h0, tbl[k].idx, 1'b0}));
      end
      chk($sformatf("t%0d_critical", k), critical_valid, tbl[k].crit);
      chk($sformatf("t%0d_write_tag", k), write_tag_array, tbl[k].tag);
      chk($sformatf("t%0d_fill_done", k), fill_done, tbl[k].done);
      if (tbl[k].busy) begin
        chk($sformatf("t%0d_fill_addr", k), fill_addr, 16'h1236);
        chk($sformatf("t%0d_grant_id", k), grant_id, 0);
      end
    end
    next_cycle();

    // Aligned D miss: no wrap.
    miss_addr_d = 16'h00F0; miss_req = 2'b10;
    n_iss = 0; n_ret = 0; got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (mem_en) begin
        chk($sformatf("aligned_addr%0d", n_iss), mem_addr, 16'h00F0 + 16'(2 * n_iss));
        n_iss++;
      end
      if (write_data_array) begin
        chk($sformatf("aligned_idx%0d", n_ret), fill_word_idx, n_ret);
        chk($sformatf("aligned_data%0d", n_ret), fill_data, mem_word(16'h00F0 + 16'(2 * n_ret)));
        n_ret++;
      end
      if (fill_done != 2'b00) begin
        got = 1'b1;
        chk("aligned_done", fill_done, 2'b10);
      end
    end
    chk("aligned_issues", n_iss, 8);
    chk("aligned_returns", n_ret, 8);
    chk("aligned_completed", got, 1);
    next_cycle();
    miss_req = 2'b00;
    next_cycle();

    // Reset during a fill at T+6.
    miss_addr_i = 16'h1236; miss_req = 2'b01;
    repeat (6) next_cycle();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_en", mem_en, 0);
    chk("midrst_write_tag", write_tag_array, 0);
    chk("midrst_fill_done", fill_done, 0);
    chk("midrst_write_data", write_data_array, 0);
    chk("midrst_fill_addr", fill_addr, 0);
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (mem_en) begin
        got = 1'b1;
        chk("restart_first_addr", mem_addr, 16'h1236);
      end
    end
    chk("restart_issued", got, 1);
    wait_done(done, gid, faddr);
    chk("restart_done", done, 2'b01);
    miss_req = 2'b00;
    next_cycle();

    // Stray returns while idle.
    stray_data = 16'hBEEF; stray_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stray%0d_write_data", k), write_data_array, 0);
      chk($sformatf("stray%0d_busy", k), busy, 0);
      next_cycle();
    end
    stray_valid = 1'b0;

    // Requester gives up mid-fill: block still written and tagged, no done.
    miss_addr_i = 16'h0100; miss_req = 2'b01;
    repeat (3) next_cycle();
    miss_req = 2'b00;
    saw_tag = 1'b0; saw_done = 1'b0; nwr = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (write_tag_array) saw_tag = 1'b1;
      if (fill_done != 2'b00) saw_done = 1'b1;
      if (write_data_array) nwr++;
    end
    chk("drop_tag_written", saw_tag, 1);
    chk("drop_no_done", saw_done, 0);
    chk("drop_words", nwr, 8);
    chk("drop_idle", busy, 0);
    next_cycle();

    // Throttled instance: latency 10, two reads in flight.
    miss_addr_i2 = 16'h2004; miss_req2 = 2'b01;
    n_iss = 0; n_ret = 0; stalls = 0; got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (busy2 && !tag2) begin
        exp_en = (n_iss < 8) && ((n_iss - n_ret) < 2);
        chk($sformatf("thr_c%0d_mem_en", n), mem_en2, exp_en);
      end
      if (mem_en2) begin
        chk($sformatf("thr_addr%0d", n_iss), mem_addr2,
            16'h2000 | 16'(((2 + n_iss) % 8) * 2));
        n_iss++;
      end else if (busy2 && !tag2 && n_iss < 8) begin
        stalls++;
      end
      if (wr2) begin
        chk($sformatf("thr_idx%0d", n_ret), idx2, (2 + n_ret) % 8);
        chk($sformatf("thr_data%0d", n_ret), fill_data2,
            mem_word(16'h2000 | 16'(((2 + n_ret) % 8) * 2)));
        n_ret++;
      end
      if (done2 != 2'b00) begin
        got = 1'b1;
        chk("thr_done", done2, 2'b01);
      end
    end
    chk("thr_stalled", stalls > 0, 1);
    chk("thr_issues", n_iss, 8);
    chk("thr_returns", n_ret, 8);
    chk("thr_completed", got, 1);
    next_cycle();
    miss_req2 = 2'b00;
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
